// File: rtl/bsg_vscale_mem_port_arbiter.sv
// Two-requester (fetch/data) memory port arbiter with round-robin grant, a grant
// lock while downstream stalls, and an in-order tag FIFO that routes responses back.
module bsg_vscale_mem_port_arbiter #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int els_p        = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [1:0]                          up_v_i,
  input  logic [1:0]                          up_w_i,
  input  logic [1:0][addr_width_p-1:0]        up_addr_i,
  input  logic [1:0][data_width_p-1:0]        up_data_i,
  input  logic [1:0][(data_width_p>>3)-1:0]   up_mask_i,
  output logic [1:0]                          up_yumi_o,
  output logic [1:0]                          up_v_o,
  output logic [1:0][data_width_p-1:0]        up_data_o,
  output logic                                down_v_o,
  output logic                                down_w_o,
  output logic [addr_width_p-1:0]             down_addr_o,
  output logic [data_width_p-1:0]             down_data_o,
  output logic [(data_width_p>>3)-1:0]        down_mask_o,
  input  logic                                down_yumi_i,
  input  logic                                down_v_i,
  input  logic [data_width_p-1:0]             down_data_i,
  output logic [$clog2(els_p+1)-1:0]          outstanding_o
);

  localparam int cnt_width_lp = $clog2(els_p+1);
  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(els_p-1);
  localparam logic [cnt_width_lp-1:0] cnt_full_lp = cnt_width_lp'(els_p);

  logic                    last_grant_r;
  logic                    lock_r;
  logic                    lock_id_r;
  logic [cnt_width_lp-1:0] count_r;
  logic [ptr_width_lp-1:0] wptr_r;
  logic [ptr_width_lp-1:0] rptr_r;
  logic                    tag_mem [els_p];

  logic grant;
  logic consume;
  logic pop;
  logic fifo_empty;
  logic head_tag;
  logic empty_resp_err;

  function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_last_lp) ? '0 : p + 1'b1;
  endfunction

  // A stalled request keeps the grant; otherwise ties go to whoever was not served last.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant = 1'b0;
    if (lock_r)
      grant = lock_id_r;
    else if (&up_v_i)
      grant = ~last_grant_r;
    else if (up_v_i[1])
      grant = 1'b1;
  end

  assign fifo_empty = (count_r == '0);
  assign head_tag   = tag_mem[rptr_r];

  assign down_v_o    = reset_n_i & up_v_i[grant] & (count_r < cnt_full_lp);
  assign down_w_o    = up_w_i[grant];
  assign down_addr_o = up_addr_i[grant];
  assign down_data_o = up_data_i[grant];
  assign down_mask_o = up_mask_i[grant];

  assign consume   = down_v_o & down_yumi_i;
  assign up_yumi_o = consume ? (grant ? 2'b10 : 2'b01) : 2'b00;

  // A response with nothing outstanding (e.g. after a reset mid-transaction) is dropped.
  assign pop            = reset_n_i & down_v_i & ~fifo_empty;
  assign empty_resp_err = reset_n_i & down_v_i & fifo_empty;
  assign up_v_o         = pop ? (head_tag ? 2'b10 : 2'b01) : 2'b00;
  assign up_data_o[0]   = down_data_i;
  assign up_data_o[1]   = down_data_i;

  assign outstanding_o = count_r;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      last_grant_r <= 1'b0;
      lock_r       <= 1'b0;
      lock_id_r    <= 1'b0;
      count_r      <= '0;
      wptr_r       <= '0;
      rptr_r       <= '0;
    end else begin
      if (consume)
        last_grant_r <= grant;

      if (down_yumi_i) begin
        lock_r <= 1'b0;
      end else if (down_v_o) begin
        lock_r    <= 1'b1;
        lock_id_r <= grant;
      end

      if (consume)
        wptr_r <= next_ptr(wptr_r);
      if (pop)
        rptr_r <= next_ptr(rptr_r);

      case ({consume, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // NOTE: the tag storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (consume)
      tag_mem[wptr_r] <= grant;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      if (lock_r)
        assert (up_v_i[lock_id_r])
          else $error("bsg_vscale_mem_port_arbiter: locked requester %0d dropped valid", lock_id_r);
      assert ($onehot0(up_yumi_o))
        else $error("bsg_vscale_mem_port_arbiter: more than one yumi asserted");
      if (empty_resp_err)
        $warning("bsg_vscale_mem_port_arbiter: downstream response with no outstanding request dropped");
    end
  end
`endif

endmodule
